// File: rtl/score_recorder.sv
// Per-user, per-song score store with a sequential three-song average engine.
// Records are captured on the rising edge of `finished` in learning mode.
module score_recorder #(
  parameter bit KEEP_BEST = 1'b0,
  parameter int SW        = 41
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    mode,
  input  logic [1:0]    user,
  input  logic [1:0]    song_num,
  input  logic          finished,
  input  logic [SW-1:0] score,
  output logic [SW-1:0] rec_score,
  output logic [SW-1:0] avg_score,
  output logic [1:0]    avg_user,
  output logic          avg_valid,
  output logic          busy
);

  localparam int CW = $clog2(SW + 2);

  typedef enum logic [1:0] {IDLE, ACC, DIV} state_t;

  logic [SW-1:0] records [16];
  logic          fin_d;
  logic [1:0]    user_d;
  logic          pend;
  state_t        state;
  logic [SW+1:0] acc;
  logic [1:0]    idx;
  logic [1:0]    rem;
  logic [CW-1:0] cnt;

  logic          write_event;
  logic          do_store;
  logic [3:0]    wr_addr;
  logic          req_busy;
  logic [SW+1:0] acc_sum;
  logic [2:0]    trial;
  logic          q_bit;
  logic [1:0]    rem_next;
  logic [SW+1:0] quo_next;

  always_comb begin
    wr_addr     = {user, song_num};
    write_event = finished & ~fin_d & (mode == 3'b111) & (song_num != 2'b11);
    do_store    = write_event & ((KEEP_BEST == 1'b0) | (score > records[wr_addr]));
    req_busy    = write_event | (user != user_d);
    acc_sum     = acc + {2'b00, records[{avg_user, idx}]};
    // acc doubles as the dividend shift register; quotient bits shift in at the LSB.
    trial       = {rem, acc[SW+1]};
    q_bit       = (trial >= 3'd3);
    // trial-3 modulo 4 equals trial+1 modulo 4, and the result is always < 3.
    rem_next    = q_bit ? (trial[1:0] + 2'd1) : trial[1:0];
    quo_next    = {acc[SW:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) records[i] <= '0;
      rec_score <= '0;
      avg_score <= '0;
      avg_user  <= 2'd0;
      avg_valid <= 1'b1;
      busy      <= 1'b0;
      pend      <= 1'b0;
      fin_d     <= 1'b0;
      user_d    <= 2'd0;
      state     <= IDLE;
      acc       <= '0;
      idx       <= 2'd0;
      rem       <= 2'd0;
      cnt       <= '0;
    end else begin
      fin_d     <= finished;
      user_d    <= user;
      if (do_store) records[wr_addr] <= score;
      rec_score <= records[{user, song_num}];

      case (state)
        IDLE: begin
          if (pend || (user != avg_user)) begin
            avg_user  <= user;
            acc       <= '0;
            idx       <= 2'd0;
            pend      <= 1'b0;
            avg_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= ACC;
          end else if (write_event) begin
            pend <= 1'b1;
          end
        end
        ACC: begin
          if (req_busy) pend <= 1'b1;
          acc <= acc_sum;
          idx <= idx + 2'd1;
          if (idx == 2'd2) begin
            rem   <= 2'd0;
            cnt   <= CW'(SW + 1);
            state <= DIV;
          end
        end
        DIV: begin
          if (req_busy) pend <= 1'b1;
          acc <= quo_next;
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            avg_score <= quo_next[SW-1:0];
            avg_valid <= ~(pend | req_busy);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_recorder.sv
// Self-checking bench for score_recorder: record model plus a queue of expected
// averages that is compared whenever the engine reports a finished result.
module tb_score_recorder;
  localparam int SW = 41;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [1:0]    user = 2'd0;
  logic [1:0]    song_num = 2'd0;
  logic          finished = 1'b0;
  logic [SW-1:0] score = '0;
  logic [SW-1:0] rec_score, avg_score, kb_rec_score, kb_avg_score;
  logic [1:0]    avg_user, kb_avg_user;
  logic          avg_valid, busy, kb_avg_valid, kb_busy;

  score_recorder #(.KEEP_BEST(1'b0), .SW(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .user(user), .song_num(song_num),
    .finished(finished), .score(score), .rec_score(rec_score),
    .avg_score(avg_score), .avg_user(avg_user), .avg_valid(avg_valid), .busy(busy)
  );

  score_recorder #(.KEEP_BEST(1'b1), .SW(SW)) dut_kb (
    .clk(clk), .rst(rst), .mode(mode), .user(user), .song_num(song_num),
    .finished(finished), .score(score), .rec_score(kb_rec_score),
    .avg_score(kb_avg_score), .avg_user(kb_avg_user), .avg_valid(kb_avg_valid), .busy(kb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    u;
    logic [SW-1:0] v;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] model [16];
  logic [SW-1:0] kb_model [16];
  int            total = 0;
  int            bad = 0;
  bit            kb_seen_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] avg_of(input logic [SW-1:0] m [16], input logic [1:0] u);
    logic [SW+1:0] s;
    logic [SW+1:0] q;
    s = {2'b00, m[{u, 2'd0}]} + {2'b00, m[{u, 2'd1}]} + {2'b00, m[{u, 2'd2}]};
    q = s / 3;
    return q[SW-1:0];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      model[i]    = '0;
      kb_model[i] = '0;
    end
  endtask

  // Wait until the engine is idle, valid and reporting the currently selected user.
  task automatic settle(input string name);
    int n = 0;
    while (!(busy == 1'b0 && avg_valid == 1'b1 && avg_user == user) && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s: settle timeout busy=%0b avg_valid=%0b avg_user=%0d required user=%0d",
               name, busy, avg_valid, avg_user, user);
    end
  endtask

  // Drive one finished pulse; update the models and scoreboard if it is a write event.
  task automatic do_write(input logic [1:0] u, input logic [1:0] s, input logic [2:0] m,
                          input logic [SW-1:0] v, input int hold, input bit push);
    user = u; song_num = s; mode = m; score = v; finished = 1'b1;
    kb_seen_busy = 1'b0;
    tick();
    if (m == 3'b111 && s != 2'b11) begin
      model[{u, s}] = v;
      if (v > kb_model[{u, s}]) kb_model[{u, s}] = v;
      if (push) sb.push_back('{u: u, v: avg_of(model, u)});
    end
    for (int i = 0; i < hold; i++) begin
      if (kb_busy) kb_seen_busy = 1'b1;
      tick();
    end
    if (kb_busy) kb_seen_busy = 1'b1;
    finished = 1'b0;
  endtask

  task automatic check_avg(input string name);
    int   n = 0;
    exp_t e;
    while (!(busy == 1'b0 && avg_valid == 1'b1) && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s: average timeout busy=%0b avg_valid=%0b", name, busy, avg_valid);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: result with empty scoreboard avg_score=%0d", name, avg_score);
    end else begin
      e = sb.pop_front();
      if (avg_user !== e.u || avg_score !== e.v) begin
        bad++;
        $display("FAIL %s: avg_user=%0d avg_score=%0d required user=%0d score=%0d",
                 name, avg_user, avg_score, e.u, e.v);
      end else begin
        $display("avg %s: user=%0d score=%0d ok", name, avg_user, avg_score);
      end
    end
  endtask

  task automatic test_reset();
    clear_models();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (avg_valid !== 1'b1 || avg_score !== '0 || busy !== 1'b0 || avg_user !== 2'd0 || rec_score !== '0) begin
      bad++;
      $display("FAIL reset: valid=%0b avg=%0d busy=%0b user=%0d rec=%0d required 1,0,0,0,0",
               avg_valid, avg_score, busy, avg_user, rec_score);
    end
    for (int a = 0; a < 16; a++) begin
      user = 2'(a >> 2);
      song_num = 2'(a);
      tick();
      total++;
      if (rec_score !== '0) begin
        bad++;
        $display("FAIL reset_rec[%0d]: rec_score=%0d required 0", a, rec_score);
      end
    end
    user = 2'd0;
    song_num = 2'd0;
    settle("reset_settle");
  endtask

  task automatic test_single_write();
    int cnt = 0;
    user = 2'd1; song_num = 2'd0; mode = 3'b111;
    settle("single_pre");
    score = SW'(90);
    finished = 1'b1;
    tick();
    model[4] = SW'(90);
    kb_model[4] = SW'(90);
    sb.push_back('{u: 2'd1, v: avg_of(model, 2'd1)});
    tick();
    total++;
    if (rec_score !== SW'(90)) begin
      bad++;
      $display("FAIL single_rec: rec_score=%0d required 90", rec_score);
    end
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == 2) score = SW'(5);
      if (cnt == 4) finished = 1'b0;
      tick();
    end
    finished = 1'b0;
    total++;
    if (cnt != 46) begin
      bad++;
      $display("FAIL single_busy: busy cycles=%0d required 46", cnt);
    end
    total++;
    if (rec_score !== SW'(90)) begin
      bad++;
      $display("FAIL single_once: rec_score=%0d required 90", rec_score);
    end
    check_avg("single_avg");
  endtask

  task automatic test_truncation();
    logic [SW-1:0] mx;
    mx = '1;
    do_write(2'd2, 2'd0, 3'b111, SW'(100), 2, 1'b1); check_avg("trunc_a");
    do_write(2'd2, 2'd1, 3'b111, SW'(100), 2, 1'b1); check_avg("trunc_b");
    do_write(2'd2, 2'd2, 3'b111, SW'(101), 2, 1'b1); check_avg("trunc_c");
    do_write(2'd2, 2'd0, 3'b111, mx, 2, 1'b1); check_avg("max_a");
    do_write(2'd2, 2'd1, 3'b111, mx, 2, 1'b1); check_avg("max_b");
    do_write(2'd2, 2'd2, 3'b111, mx, 2, 1'b1); check_avg("max_c");
  endtask

  task automatic test_gating();
    bit saw_busy = 1'b0;
    user = 2'd1; song_num = 2'd1; mode = 3'b111;
    settle("gate_pre");
    do_write(2'd1, 2'd1, 3'b011, SW'(55), 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (busy) saw_busy = 1'b1;
      tick();
    end
    do_write(2'd1, 2'd3, 3'b111, SW'(66), 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (busy) saw_busy = 1'b1;
      tick();
    end
    total++;
    if (saw_busy || rec_score !== '0) begin
      bad++;
      $display("FAIL gate_avg_view: busy_seen=%0b rec_score=%0d required 0,0", saw_busy, rec_score);
    end
    song_num = 2'd1;
    tick();
    total++;
    if (rec_score !== model[5]) begin
      bad++;
      $display("FAIL gate_mode: rec_score=%0d required %0d", rec_score, model[5]);
    end
  endtask

  task automatic test_keep_best();
    logic [SW-1:0] vals [3];
    vals[0] = SW'(80); vals[1] = SW'(70); vals[2] = SW'(85);
    user = 2'd3; song_num = 2'd1; mode = 3'b111;
    settle("kb_pre");
    for (int i = 0; i < 3; i++) begin
      do_write(2'd3, 2'd1, 3'b111, vals[i], 2, 1'b1);
      check_avg("kb_main");
      total++;
      if (kb_rec_score !== kb_model[13] || !kb_seen_busy) begin
        bad++;
        $display("FAIL kb_rec[%0d]: rec_score=%0d busy_seen=%0b required %0d,1",
                 i, kb_rec_score, kb_seen_busy, kb_model[13]);
      end
      total++;
      if (kb_avg_score !== avg_of(kb_model, 2'd3) || kb_avg_valid !== 1'b1) begin
        bad++;
        $display("FAIL kb_avg[%0d]: avg_score=%0d valid=%0b required %0d,1",
                 i, kb_avg_score, kb_avg_valid, avg_of(kb_model, 2'd3));
      end
    end
  endtask

  task automatic test_interrupt();
    int n = 0;
    int cnt = 0;
    user = 2'd0; song_num = 2'd0; mode = 3'b111;
    settle("int_pre");
    do_write(2'd0, 2'd0, 3'b111, SW'(300), 2, 1'b0);
    repeat (22) tick();
    user = 2'd3;
    sb.push_back('{u: 2'd3, v: avg_of(model, 2'd3)});
    while (busy && n < 200) begin
      total++;
      if (avg_valid !== 1'b0) begin
        bad++;
        $display("FAIL int_valid_low: avg_valid=%0b required 0 during run", avg_valid);
      end
      tick();
      n++;
    end
    total++;
    if (avg_valid !== 1'b0) begin
      bad++;
      $display("FAIL int_stale: avg_valid=%0b required 0 after interrupted run", avg_valid);
    end
    tick();
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt != 46) begin
      bad++;
      $display("FAIL int_rerun: busy cycles=%0d required 46", cnt);
    end
    check_avg("int_user3");
  endtask

  task automatic test_reset_mid_div();
    do_write(2'd3, 2'd2, 3'b111, SW'(777), 2, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_models();
    total++;
    if (avg_valid !== 1'b1 || busy !== 1'b0 || avg_score !== '0 || avg_user !== 2'd0 || rec_score !== '0) begin
      bad++;
      $display("FAIL rst_mid: valid=%0b busy=%0b avg=%0d user=%0d rec=%0d required 1,0,0,0,0",
               avg_valid, busy, avg_score, avg_user, rec_score);
    end
    sb.push_back('{u: 2'd3, v: '0});
    tick();
    total++;
    if (rec_score !== '0) begin
      bad++;
      $display("FAIL rst_rec: rec_score=%0d required 0", rec_score);
    end
    check_avg("rst_rerun");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_truncation();
    test_gating();
    test_keep_best();
    test_interrupt();
    test_reset_mid_div();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: entries=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
